// File: rtl/vx_commit_arbiter.sv
// Commit arbiter for one issue slot: merges ALU/LSU/FPU/SFU commit beats into one
// registered writeback stream with round-robin arbitration, a grant that stays on one
// source for the whole sop..eop packet, and the retired-instruction counter.
module vx_commit_arbiter #(
    parameter int unsigned NUM_REQS    = 4,
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned NW_BITS     = 2,
    parameter int unsigned NR_BITS     = 5,
    parameter int unsigned XLEN        = 32,
    localparam int unsigned SRC_W      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int unsigned DATA_W     = NUM_THREADS * XLEN
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQS-1:0]             in_valid,
    output logic [NUM_REQS-1:0]             in_ready,
    input  logic [NUM_REQS*NW_BITS-1:0]     in_wid,
    input  logic [NUM_REQS*NUM_THREADS-1:0] in_tmask,
    input  logic [NUM_REQS*XLEN-1:0]        in_pc,
    input  logic [NUM_REQS-1:0]             in_wb,
    input  logic [NUM_REQS*NR_BITS-1:0]     in_rd,
    input  logic [NUM_REQS*DATA_W-1:0]      in_data,
    input  logic [NUM_REQS-1:0]             in_eop,
    output logic                            wb_valid,
    input  logic                            wb_ready,
    output logic [NW_BITS-1:0]              wb_wid,
    output logic [NUM_THREADS-1:0]          wb_tmask,
    output logic [XLEN-1:0]                 wb_pc,
    output logic                            wb_wb,
    output logic [NR_BITS-1:0]              wb_rd,
    output logic [DATA_W-1:0]               wb_data,
    output logic                            wb_eop,
    output logic [SRC_W-1:0]                wb_src,
    output logic [63:0]                     instret
);

    logic [SRC_W-1:0]       rr_ptr;
    logic                   lock;
    logic [SRC_W-1:0]       lock_src;

    logic                   load;
    logic                   fire;
    logic                   grant_valid;
    logic [SRC_W-1:0]       grant;
    logic [SRC_W-1:0]       grant_inc;
    int                     idx;

    logic [NW_BITS-1:0]     sel_wid;
    logic [NUM_THREADS-1:0] sel_tmask;
    logic [XLEN-1:0]        sel_pc;
    logic                   sel_wb;
    logic [NR_BITS-1:0]     sel_rd;
    logic [DATA_W-1:0]      sel_data;
    logic                   sel_eop;

    assign load = !wb_valid || wb_ready;
    assign fire = load && grant_valid;
    assign grant_inc = (grant == SRC_W'(NUM_REQS - 1)) ? '0 : SRC_W'(grant + SRC_W'(1));

    // Grant: locked source only, else first valid source at or after rr_ptr (wrapping).
    // Scanning from the farthest candidate back to rr_ptr lets the nearest one win.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        if (lock) begin
            grant       = lock_src;
            grant_valid = in_valid[lock_src];
        end else begin
            for (int k = int'(NUM_REQS) - 1; k >= 0; k--) begin
                idx = int'(rr_ptr) + k;
                if (idx >= int'(NUM_REQS)) begin
                    idx = idx - int'(NUM_REQS);
                end
                if (in_valid[idx[SRC_W-1:0]]) begin
                    grant       = idx[SRC_W-1:0];
                    grant_valid = 1'b1;
                end
            end
        end
    end

    // Only the granted source sees ready; held low while reset is asserted.
    always_comb begin
        in_ready = '0;
        if (reset && fire) begin
            in_ready[grant] = 1'b1;
        end
    end

    // Payload mux for the granted source.
    always_comb begin
        sel_wid   = '0;
        sel_tmask = '0;
        sel_pc    = '0;
        sel_wb    = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        sel_eop   = 1'b0;
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            if (grant == SRC_W'(i)) begin
                sel_wid   = in_wid[i*NW_BITS +: NW_BITS];
                sel_tmask = in_tmask[i*NUM_THREADS +: NUM_THREADS];
                sel_pc    = in_pc[i*XLEN +: XLEN];
                sel_wb    = in_wb[i];
                sel_rd    = in_rd[i*NR_BITS +: NR_BITS];
                sel_data  = in_data[i*DATA_W +: DATA_W];
                sel_eop   = in_eop[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid <= 1'b0;
            wb_wid   <= '0;
            wb_tmask <= '0;
            wb_pc    <= '0;
            wb_wb    <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wb_eop   <= 1'b0;
            wb_src   <= '0;
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_src <= '0;
        end else if (fire) begin
            wb_valid <= 1'b1;
            wb_wid   <= sel_wid;
            wb_tmask <= sel_tmask;
            wb_pc    <= sel_pc;
            wb_wb    <= sel_wb;
            wb_rd    <= sel_rd;
            wb_data  <= sel_data;
            wb_eop   <= sel_eop;
            wb_src   <= grant;
            if (sel_eop) begin
                rr_ptr <= grant_inc;
                lock   <= 1'b0;
            end else begin
                lock     <= 1'b1;
                lock_src <= grant;
            end
        end else if (load) begin
            wb_valid <= 1'b0;
        end
    end

    // Retirement is counted at the output handshake of the last beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret <= '0;
        end else if (wb_valid && wb_ready && wb_eop) begin
            instret <= instret + 64'd1;
        end
    end

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Directed bench for vx_commit_arbiter: a vector table for round-robin order plus
// hand-written sequences for packet lock, backpressure, wb=0 retire and async reset.
module tb_vx_commit_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [7:0]   in_wid;
    logic [15:0]  in_tmask;
    logic [127:0] in_pc;
    logic [3:0]   in_wb;
    logic [19:0]  in_rd;
    logic [511:0] in_data;
    logic [3:0]   in_eop;
    logic         wb_valid;
    logic         wb_ready;
    logic [1:0]   wb_wid;
    logic [3:0]   wb_tmask;
    logic [31:0]  wb_pc;
    logic         wb_wb;
    logic [4:0]   wb_rd;
    logic [127:0] wb_data;
    logic         wb_eop;
    logic [1:0]   wb_src;
    logic [63:0]  instret;

    int total;
    int bad;

    vx_commit_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_wid   (in_wid),
        .in_tmask (in_tmask),
        .in_pc    (in_pc),
        .in_wb    (in_wb),
        .in_rd    (in_rd),
        .in_data  (in_data),
        .in_eop   (in_eop),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_wid   (wb_wid),
        .wb_tmask (wb_tmask),
        .wb_pc    (wb_pc),
        .wb_wb    (wb_wb),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .wb_eop   (wb_eop),
        .wb_src   (wb_src),
        .instret  (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  exp_ready;
        logic        exp_wbv;
        logic [1:0]  exp_src;
        logic [63:0] exp_instret;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one source; thread t data is pc+t, rd is src+1, wid is src.
    task automatic drive(input int i, input logic v, input logic eop, input logic wb,
                         input logic [31:0] pc);
        in_valid[i]           = v;
        in_eop[i]             = eop;
        in_wb[i]              = wb;
        in_pc[i*32 +: 32]     = pc;
        in_wid[i*2 +: 2]      = 2'(i);
        in_tmask[i*4 +: 4]    = 4'hF;
        in_rd[i*5 +: 5]       = 5'(i + 1);
        for (int t = 0; t < 4; t++) begin
            in_data[(i*4+t)*32 +: 32] = pc + 32'(t);
        end
    endtask

    task automatic clear_inputs();
        in_valid = '0;
        in_wid   = '0;
        in_tmask = '0;
        in_pc    = '0;
        in_wb    = '0;
        in_rd    = '0;
        in_data  = '0;
        in_eop   = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        wb_ready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        wb_ready = 1'b1;
        clear_inputs();

        vecs[0]  = '{4'b1111, 4'b0001, 1'b0, 2'd0, 64'd0};
        vecs[1]  = '{4'b1111, 4'b0010, 1'b1, 2'd0, 64'd0};
        vecs[2]  = '{4'b1111, 4'b0100, 1'b1, 2'd1, 64'd1};
        vecs[3]  = '{4'b1111, 4'b1000, 1'b1, 2'd2, 64'd2};
        vecs[4]  = '{4'b1111, 4'b0001, 1'b1, 2'd3, 64'd3};
        vecs[5]  = '{4'b1111, 4'b0010, 1'b1, 2'd0, 64'd4};
        vecs[6]  = '{4'b1111, 4'b0100, 1'b1, 2'd1, 64'd5};
        vecs[7]  = '{4'b1111, 4'b1000, 1'b1, 2'd2, 64'd6};
        vecs[8]  = '{4'b0000, 4'b0000, 1'b1, 2'd3, 64'd7};
        vecs[9]  = '{4'b0000, 4'b0000, 1'b0, 2'd0, 64'd8};
        vecs[10] = '{4'b1010, 4'b0010, 1'b0, 2'd0, 64'd8};
        vecs[11] = '{4'b1010, 4'b1000, 1'b1, 2'd1, 64'd8};
        vecs[12] = '{4'b1010, 4'b0010, 1'b1, 2'd3, 64'd9};
        vecs[13] = '{4'b0000, 4'b0000, 1'b1, 2'd1, 64'd10};
        vecs[14] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 64'd11};

        // Reset state, with every source requesting.
        for (int i = 0; i < 4; i++) drive(i, 1'b1, 1'b1, 1'b1, 32'h1111_0000 + 32'(i));
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        chk("rst_wb_valid", 64'(wb_valid), 64'h0);
        chk("rst_wb_pc", 64'(wb_pc), 64'h0);
        chk("rst_wb_src", 64'(wb_src), 64'h0);
        chk("rst_instret", instret, 64'h0);

        // ALU alone: ready in cycle 0, output in cycle 1, retired count in cycle 2.
        do_reset();
        drive(0, 1'b1, 1'b1, 1'b1, 32'h8000_0000);
        #1 chk("alu_ready", 64'(in_ready), 64'b0001);
        tick();
        drive(0, 1'b0, 1'b1, 1'b1, 32'h8000_0000);
        #1;
        chk("alu_wb_valid", 64'(wb_valid), 64'h1);
        chk("alu_wb_pc", 64'(wb_pc), 64'h8000_0000);
        chk("alu_wb_src", 64'(wb_src), 64'h0);
        chk("alu_wb_data3", 64'(wb_data[127:96]), 64'h8000_0003);
        chk("alu_instret_c1", instret, 64'h0);
        tick();
        chk("alu_instret_c2", instret, 64'h1);
        chk("alu_wb_valid_c2", 64'(wb_valid), 64'h0);

        // Round-robin vector table.
        do_reset();
        for (int r = 0; r < 15; r++) begin
            for (int i = 0; i < 4; i++)
                drive(i, vecs[r].valid[i], 1'b1, 1'b1, 32'h8000_0000 + 32'(i * 256));
            #1;
            chk($sformatf("rr%0d_ready", r), 64'(in_ready), 64'(vecs[r].exp_ready));
            chk($sformatf("rr%0d_wbv", r), 64'(wb_valid), 64'(vecs[r].exp_wbv));
            chk($sformatf("rr%0d_instret", r), instret, vecs[r].exp_instret);
            if (vecs[r].exp_wbv) begin
                chk($sformatf("rr%0d_src", r), 64'(wb_src), 64'(vecs[r].exp_src));
                chk($sformatf("rr%0d_pc", r), 64'(wb_pc),
                    64'(32'h8000_0000 + 32'(int'(vecs[r].exp_src) * 256)));
                chk($sformatf("rr%0d_rd", r), 64'(wb_rd), 64'(int'(vecs[r].exp_src) + 1));
            end
            tick();
        end

        // LSU three-beat packet with a valid gap; ALU must wait for the eop beat.
        do_reset();
        drive(1, 1'b1, 1'b0, 1'b1, 32'h2000);
        #1 chk("lk_a_ready", 64'(in_ready), 64'b0010);
        tick();
        drive(0, 1'b1, 1'b1, 1'b1, 32'h1000);
        drive(1, 1'b1, 1'b0, 1'b1, 32'h2004);
        #1;
        chk("lk_b_ready", 64'(in_ready), 64'b0010);
        chk("lk_b_pc", 64'(wb_pc), 64'h2000);
        chk("lk_b_eop", 64'(wb_eop), 64'h0);
        tick();
        drive(1, 1'b0, 1'b0, 1'b1, 32'h2004);
        #1;
        chk("lk_c_ready", 64'(in_ready), 64'b0000);
        chk("lk_c_pc", 64'(wb_pc), 64'h2004);
        tick();
        drive(1, 1'b1, 1'b1, 1'b1, 32'h2008);
        #1;
        chk("lk_d_ready", 64'(in_ready), 64'b0010);
        chk("lk_d_wbv", 64'(wb_valid), 64'h0);
        chk("lk_d_instret", instret, 64'h0);
        tick();
        drive(1, 1'b0, 1'b1, 1'b1, 32'h2008);
        #1;
        chk("lk_e_ready", 64'(in_ready), 64'b0001);
        chk("lk_e_pc", 64'(wb_pc), 64'h2008);
        chk("lk_e_eop", 64'(wb_eop), 64'h1);
        tick();
        drive(0, 1'b0, 1'b1, 1'b1, 32'h1000);
        #1;
        chk("lk_f_src", 64'(wb_src), 64'h0);
        chk("lk_f_pc", 64'(wb_pc), 64'h1000);
        chk("lk_f_instret", instret, 64'h1);
        tick();
        chk("lk_g_instret", instret, 64'h2);

        // Backpressure on an SFU beat, then drain and reload with no bubble.
        do_reset();
        drive(3, 1'b1, 1'b1, 1'b1, 32'h4000);
        #1 chk("bp_load_ready", 64'(in_ready), 64'b1000);
        tick();
        wb_ready = 1'b0;
        drive(3, 1'b1, 1'b1, 1'b1, 32'h4004);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp%0d_ready", c), 64'(in_ready), 64'h0);
            chk($sformatf("bp%0d_wbv", c), 64'(wb_valid), 64'h1);
            chk($sformatf("bp%0d_pc", c), 64'(wb_pc), 64'h4000);
            chk($sformatf("bp%0d_instret", c), instret, 64'h0);
            tick();
        end
        wb_ready = 1'b1;
        #1 chk("bp_drain_ready", 64'(in_ready), 64'b1000);
        tick();
        drive(3, 1'b0, 1'b1, 1'b1, 32'h4004);
        #1;
        chk("bp_next_wbv", 64'(wb_valid), 64'h1);
        chk("bp_next_pc", 64'(wb_pc), 64'h4004);
        chk("bp_next_instret", instret, 64'h1);
        tick();
        chk("bp_end_instret", instret, 64'h2);

        // FPU beat with wb=0 still passes through and retires.
        do_reset();
        drive(2, 1'b1, 1'b1, 1'b0, 32'h3000);
        #1 chk("nowb_ready", 64'(in_ready), 64'b0100);
        tick();
        drive(2, 1'b0, 1'b1, 1'b0, 32'h3000);
        #1;
        chk("nowb_wbv", 64'(wb_valid), 64'h1);
        chk("nowb_wb", 64'(wb_wb), 64'h0);
        chk("nowb_src", 64'(wb_src), 64'h2);
        tick();
        chk("nowb_instret", instret, 64'h1);

        // Async reset in the middle of a locked LSU packet.
        do_reset();
        drive(0, 1'b1, 1'b1, 1'b1, 32'h5000);
        tick();
        drive(0, 1'b0, 1'b1, 1'b1, 32'h5000);
        drive(1, 1'b1, 1'b0, 1'b1, 32'h6000);
        #1 chk("ar_lsu_ready", 64'(in_ready), 64'b0010);
        tick();
        for (int i = 0; i < 4; i++) drive(i, 1'b1, 1'b1, 1'b1, 32'h7000 + 32'(i));
        drive(1, 1'b1, 1'b0, 1'b1, 32'h6004);
        #1;
        chk("ar_locked_ready", 64'(in_ready), 64'b0010);
        chk("ar_pre_instret", instret, 64'h1);
        chk("ar_pre_wbv", 64'(wb_valid), 64'h1);
        #2 reset = 1'b0;
        #1;
        chk("ar_wbv", 64'(wb_valid), 64'h0);
        chk("ar_instret", instret, 64'h0);
        chk("ar_pc", 64'(wb_pc), 64'h0);
        chk("ar_ready_in_rst", 64'(in_ready), 64'h0);
        reset = 1'b1;
        #1 chk("ar_post_ready", 64'(in_ready), 64'b0001);
        tick();
        #1 chk("ar_post_src", 64'(wb_src), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vx_commit_arbiter.md
# vx_commit_arbiter

Per-issue-slot commit arbiter that sits directly downstream of the execute stage. It merges the ALU, LSU, FPU and SFU commit streams of one issue slot into a single registered writeback stream for the register file and scoreboard release. It also maintains the retired-instruction counter used by the CSR unit. Arbitration is round-robin, and the grant is locked across multi-beat (sop..eop) commits.

## Interface
Parameters:
- NUM_REQS, 4, number of commit sources (0=ALU, 1=LSU, 2=FPU, 3=SFU)
- NUM_THREADS, 4, threads per warp
- NW_BITS, 2, warp id width
- NR_BITS, 5, register index width
- XLEN, 32, data/PC width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, asynchronous, active-low
- in_valid  in  NUM_REQS  source has a commit beat
- in_ready  out  NUM_REQS  beat accepted this cycle
- in_wid  in  NUM_REQS*NW_BITS  warp id
- in_tmask  in  NUM_REQS*NUM_THREADS  thread mask
- in_pc  in  NUM_REQS*XLEN  instruction PC
- in_wb  in  NUM_REQS  beat writes rd
- in_rd  in  NUM_REQS*NR_BITS  destination register
- in_data  in  NUM_REQS*NUM_THREADS*XLEN  per-thread result
- in_eop  in  NUM_REQS  last beat of the instruction
- wb_valid  out  1  output beat valid
- wb_ready  in  1  downstream accepts
- wb_wid, wb_tmask, wb_pc, wb_wb, wb_rd, wb_data, wb_eop  out  (field widths)  registered copy of the granted beat
- wb_src  out  2  index of the source that produced the beat
- instret  out  64  count of retired instructions

## Operation
- Output register: `load = !wb_valid || wb_ready`. `in_ready[i] = load && in_valid[i] && grant==i`. At most one in_ready bit is high.
- Arbitration when unlocked: round-robin over `in_valid`. Priority starts at pointer `rr_ptr` and wraps modulo NUM_REQS.
- Pointer update: after any accepted beat with `in_eop=1`, `rr_ptr <= grant+1` (mod NUM_REQS). The pointer is unchanged otherwise.
- Lock: an accepted beat with `in_eop=0` sets `lock=1` and `lock_src=grant`.
  - While locked, grant is `lock_src` only, even if that source deasserts `in_valid`; other sources stall.
  - The accepted eop beat clears `lock`.
- No valid input, or `load=0`: no grant. `rr_ptr` and `lock` hold.
- On load with a handshake, all wb_* fields take the granted beat and `wb_valid <= 1`. On load without a handshake, `wb_valid <= 0`.
- Outputs are stable while `wb_valid && !wb_ready`.
- `wb_wb=0` beats still pass through, because they are needed for retirement and scoreboard release.
- instret: increments by 1 on an output handshake (`wb_valid && wb_ready`) with `wb_eop=1`. Wraps modulo 2^64.
- A beat with `in_tmask=0` is illegal; the block takes no special action.

## Timing
- Reset (async assert, sync-safe deassert) drives the following values:
  - wb_valid=0
  - all wb_* fields=0
  - wb_src=0
  - instret=0
  - rr_ptr=0
  - lock=0
  - in_ready=0
- Latency: input handshake in cycle N gives wb_valid in cycle N+1.
- Throughput: 1 beat/cycle while wb_ready=1.
- `in_ready` is combinational from `in_valid`, `wb_ready`, `wb_valid`, `rr_ptr` and `lock`. There is no combinational path from inputs to wb_*.
- Simultaneous output drain and new load in the same cycle gives no bubble.
- instret updates the cycle after the retiring output handshake.
- Reset asserted mid-lock or mid-backpressure: state is cleared immediately and the in-flight beat is dropped. Sources must also be reset.

## Test plan
- Reset, then ALU only: `in_valid=0001`, `eop=1`, `pc=0x80000000`, `wb_ready=1`. Expect `in_ready=0001` in cycle 0; `wb_valid=1`, `wb_pc=0x80000000`, `wb_src=0` in cycle 1; `instret=1` in cycle 2.
- All four valid with `eop=1` continuously and `wb_ready=1`. Grant order is 0,1,2,3,0,... After 8 cycles, `instret=8`.
- LSU sends 3 beats (eop on the 3rd) while ALU stays valid and LSU drops valid for 1 cycle mid-packet. ALU is never granted until the LSU eop beat. Then ALU is granted next, with `rr_ptr=2` wrapping to 0.
- Backpressure: `wb_ready=0` for 5 cycles with SFU valid. wb_* stays stable, `in_ready=0`, instret is unchanged. On `wb_ready=1`, the held beat drains and the next beat loads with no gap.
- `wb=0` beat from FPU with `eop=1`: it is passed with `wb_wb=0` and instret increments.
- Async reset asserted mid-lock: wb_valid, lock, rr_ptr and instret all become 0 before the next clock edge. After release, source 0 wins first.
